// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared state enum, default sizes and select-width helper for stream_mux_nto1
package stream_mux_pkg;

  localparam int DEF_N = 4;
  localparam int DEF_W = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Select width is clog2(N), but never narrower than one bit
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_mux_rr_pick.sv
// rtl/stream_mux_rr_pick.sv - combinational round-robin candidate finder, searches from ptr+1 modulo N
module stream_mux_rr_pick
  import stream_mux_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int SW = sel_width(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] idx,
  output logic          found
);

  // Walk distances 1..N from the pointer; the first valid channel wins
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      for (int c = 0; c < N; c++) begin
        if (!found && valid[c] && (((int'(ptr) + k) % N) == c)) begin
          idx   = SW'(c);
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/stream_mux_nto1.sv
// rtl/stream_mux_nto1.sv - N-to-1 packet-locking stream mux with a one-slot output register; STREAM_MUX_RR_EN selects round-robin arbitration
module stream_mux_nto1
  import stream_mux_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W,
  localparam int SW = sel_width(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [SW-1:0]  sel,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  input  logic [N-1:0]   in_last,
  output logic [N-1:0]   in_ready,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  output logic           out_last,
  input  logic           out_ready
);

  state_t        state;
  logic [SW-1:0] chan;
  logic          slot_free;
  logic [SW-1:0] cand_idx;
  logic          cand_ok;
  logic [SW-1:0] cur_idx;
  logic [W-1:0]  mux_data;
  logic          mux_last;
  logic          xfer;

  assign slot_free = !out_valid || out_ready;

`ifdef STREAM_MUX_RR_EN
  logic [SW-1:0] ptr;

  stream_mux_rr_pick #(
    .N  (N),
    .SW (SW)
  ) u_pick (
    .valid (in_valid),
    .ptr   (ptr),
    .idx   (cand_idx),
    .found (cand_ok)
  );
`else
  assign cand_idx = sel;
  assign cand_ok  = ({1'b0, sel} < (SW+1)'(N));
`endif

  // Locked channel wins; otherwise the IDLE candidate is the source
  assign cur_idx = (state == LOCKED) ? chan : cand_idx;

  // Steer the active channel's beat to the slot and grant only that channel
  always_comb begin
    in_ready = '0;
    mux_data = '0;
    mux_last = 1'b0;
    for (int c = 0; c < N; c++) begin
      if (cur_idx == SW'(c)) begin
        mux_data = in_data[c*W +: W];
        mux_last = in_last[c];
        if (!rst && slot_free) begin
          if (state == LOCKED) begin
            in_ready[c] = 1'b1;
          end else if (cand_ok) begin
            in_ready[c] = in_valid[c];
          end
        end
      end
    end
  end

  assign xfer = |(in_ready & in_valid);

  // Packet lock FSM and output slot, loaded on every accepted beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      chan      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
`ifdef STREAM_MUX_RR_EN
      ptr       <= SW'(N - 1);
`endif
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= mux_data;
        out_last  <= mux_last;
        if (state == IDLE) begin
          if (!mux_last) begin
            state <= LOCKED;
            chan  <= cand_idx;
          end
`ifdef STREAM_MUX_RR_EN
          ptr <= cand_idx;
`endif
        end else if (mux_last) begin
          state <= IDLE;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_nto1.sv
// tb/tb_stream_mux_nto1.sv - directed self-checking bench for stream_mux_nto1 (N=4 main instance, N=5 instance for out-of-range select)
module tb_stream_mux_nto1;
  import stream_mux_pkg::*;

  logic        clk;
  logic        rst;
  logic [1:0]  sel;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_last;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;

  logic [2:0]  sel5;
  logic [39:0] in_data5;
  logic [4:0]  in_valid5;
  logic [4:0]  in_last5;
  logic [4:0]  in_ready5;
  logic [7:0]  out_data5;
  logic        out_valid5;
  logic        out_last5;
  logic        out_ready5;

  int pass_cnt;
  int total_cnt;

  stream_mux_nto1 #(.N(4), .W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  stream_mux_nto1 #(.N(5), .W(8)) dut5 (
    .clk       (clk),
    .rst       (rst),
    .sel       (sel5),
    .in_data   (in_data5),
    .in_valid  (in_valid5),
    .in_last   (in_last5),
    .in_ready  (in_ready5),
    .out_data  (out_data5),
    .out_valid (out_valid5),
    .out_last  (out_last5),
    .out_ready (out_ready5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic [7:0] d, input logic v, input logic l);
    in_data[c*8 +: 8] = d;
    in_valid[c] = v;
    in_last[c] = l;
  endtask

  task automatic test_reset();
    rst = 1'b1; sel = '0; in_data = '0; in_valid = 4'hF; in_last = '0; out_ready = 1'b1;
    sel5 = '0; in_data5 = '0; in_valid5 = '0; in_last5 = '0; out_ready5 = 1'b1;
    #2;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== 8'h00) $display("FAIL reset_out_data got %h exp 00", out_data); else pass_cnt++;
    total_cnt++; if (out_last !== 1'b0) $display("FAIL reset_out_last got %b exp 0", out_last); else pass_cnt++;
    total_cnt++; if (dut.state !== IDLE) $display("FAIL reset_state got %0d exp IDLE", dut.state); else pass_cnt++;
    total_cnt++; if (dut.chan !== 2'd0) $display("FAIL reset_chan got %0d exp 0", dut.chan); else pass_cnt++;
    total_cnt++; if (in_ready !== 4'b0000) $display("FAIL reset_in_ready got %b exp 0000", in_ready); else pass_cnt++;
`ifdef STREAM_MUX_RR_EN
    total_cnt++; if (dut.ptr !== 2'd3) $display("FAIL reset_ptr got %0d exp 3", dut.ptr); else pass_cnt++;
`endif
    step();
    step();
    in_valid = '0;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_basic();
    sel = 2'd2; out_ready = 1'b1;
    set_ch(2, 8'h11, 1'b1, 1'b0);
    #1;
    total_cnt++; if (in_ready !== 4'b0100) $display("FAIL basic_ready0 got %b exp 0100", in_ready); else pass_cnt++;
    step();
    total_cnt++; if (out_valid !== 1'b1 || out_data !== 8'h11 || out_last !== 1'b0)
      $display("FAIL basic_beat0 got v=%b d=%h l=%b exp v=1 d=11 l=0", out_valid, out_data, out_last); else pass_cnt++;
    set_ch(2, 8'h22, 1'b1, 1'b0);
    #1;
    total_cnt++; if (in_ready !== 4'b0100) $display("FAIL basic_ready1 got %b exp 0100", in_ready); else pass_cnt++;
    step();
    total_cnt++; if (out_valid !== 1'b1 || out_data !== 8'h22 || out_last !== 1'b0)
      $display("FAIL basic_beat1 got v=%b d=%h l=%b exp v=1 d=22 l=0", out_valid, out_data, out_last); else pass_cnt++;
    set_ch(2, 8'h33, 1'b1, 1'b1);
    step();
    total_cnt++; if (out_valid !== 1'b1 || out_data !== 8'h33 || out_last !== 1'b1)
      $display("FAIL basic_beat2 got v=%b d=%h l=%b exp v=1 d=33 l=1", out_valid, out_data, out_last); else pass_cnt++;
    total_cnt++; if (dut.state !== IDLE) $display("FAIL basic_state got %0d exp IDLE", dut.state); else pass_cnt++;
    set_ch(2, 8'h00, 1'b0, 1'b0);
    step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL basic_drain got %b exp 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_lock();
    sel = 2'd1; out_ready = 1'b1;
    set_ch(1, 8'hA1, 1'b1, 1'b0);
    step();
    sel = 2'd3;
    set_ch(3, 8'hC3, 1'b1, 1'b1);
    set_ch(1, 8'hA2, 1'b1, 1'b0);
    #1;
    total_cnt++; if (in_ready !== 4'b0010) $display("FAIL lock_ready0 got %b exp 0010", in_ready); else pass_cnt++;
    step();
    total_cnt++; if (out_data !== 8'hA2) $display("FAIL lock_beat1 got %h exp a2", out_data); else pass_cnt++;
    set_ch(1, 8'hA3, 1'b1, 1'b1);
    #1;
    total_cnt++; if (in_ready !== 4'b0010) $display("FAIL lock_ready1 got %b exp 0010", in_ready); else pass_cnt++;
    step();
    total_cnt++; if (out_data !== 8'hA3 || out_last !== 1'b1)
      $display("FAIL lock_last got d=%h l=%b exp d=a3 l=1", out_data, out_last); else pass_cnt++;
    set_ch(1, 8'h00, 1'b0, 1'b0);
    #1;
    total_cnt++; if (in_ready !== 4'b1000) $display("FAIL lock_ready_ch3 got %b exp 1000", in_ready); else pass_cnt++;
    step();
    total_cnt++; if (out_valid !== 1'b1 || out_data !== 8'hC3 || out_last !== 1'b1)
      $display("FAIL lock_ch3_beat got v=%b d=%h l=%b exp v=1 d=c3 l=1", out_valid, out_data, out_last); else pass_cnt++;
    set_ch(3, 8'h00, 1'b0, 1'b0);
    step();
  endtask

  task automatic test_backpressure();
    sel = 2'd0; out_ready = 1'b0;
    set_ch(0, 8'h51, 1'b1, 1'b1);
    #1;
    total_cnt++; if (in_ready !== 4'b0001) $display("FAIL bp_ready_empty got %b exp 0001", in_ready); else pass_cnt++;
    step();
    set_ch(0, 8'h52, 1'b1, 1'b1);
    #1;
    for (int i = 0; i < 3; i++) begin
      total_cnt++; if (out_valid !== 1'b1 || out_data !== 8'h51)
        $display("FAIL bp_hold%0d got v=%b d=%h exp v=1 d=51", i, out_valid, out_data); else pass_cnt++;
      total_cnt++; if (in_ready !== 4'b0000) $display("FAIL bp_ready_full%0d got %b exp 0000", i, in_ready); else pass_cnt++;
      step();
    end
    out_ready = 1'b1;
    #1;
    total_cnt++; if (in_ready !== 4'b0001) $display("FAIL bp_ready_drain got %b exp 0001", in_ready); else pass_cnt++;
    step();
    set_ch(0, 8'h00, 1'b0, 1'b0);
    #1;
    total_cnt++; if (out_valid !== 1'b1 || out_data !== 8'h52)
      $display("FAIL bp_next got v=%b d=%h exp v=1 d=52", out_valid, out_data); else pass_cnt++;
    step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_no_dup got %b exp 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d;
    sel = 2'd3; out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      exp_d = 8'(i);
      set_ch(3, exp_d, 1'b1, 1'b1);
      step();
      total_cnt++; if (out_valid !== 1'b1 || out_data !== exp_d || out_last !== 1'b1)
        $display("FAIL b2b_beat%0d got v=%b d=%h l=%b exp v=1 d=%h l=1", i, out_valid, out_data, out_last, exp_d); else pass_cnt++;
    end
    set_ch(3, 8'h00, 1'b0, 1'b0);
    step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL b2b_drain got %b exp 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_sel_range();
    in_data5 = {8'h44, 8'h33, 8'h22, 8'h11, 8'h00};
    in_valid5 = 5'b11111; in_last5 = 5'b11111; out_ready5 = 1'b1;
    sel5 = 3'd5;
    #1;
    for (int i = 0; i < 3; i++) begin
      total_cnt++; if (in_ready5 !== 5'b00000) $display("FAIL range_ready%0d got %b exp 00000", i, in_ready5); else pass_cnt++;
      step();
      total_cnt++; if (out_valid5 !== 1'b0) $display("FAIL range_valid%0d got %b exp 0", i, out_valid5); else pass_cnt++;
    end
    sel5 = 3'd7;
    #1;
    total_cnt++; if (in_ready5 !== 5'b00000) $display("FAIL range_ready_sel7 got %b exp 00000", in_ready5); else pass_cnt++;
    sel5 = 3'd4;
    #1;
    total_cnt++; if (in_ready5 !== 5'b10000) $display("FAIL range_ready_sel4 got %b exp 10000", in_ready5); else pass_cnt++;
    step();
    total_cnt++; if (out_valid5 !== 1'b1 || out_data5 !== 8'h44)
      $display("FAIL range_beat_sel4 got v=%b d=%h exp v=1 d=44", out_valid5, out_data5); else pass_cnt++;
    in_valid5 = '0;
    step();
  endtask

  task automatic test_reset_mid();
    sel = 2'd0; out_ready = 1'b1;
    set_ch(0, 8'hD1, 1'b1, 1'b0);
    step();
    set_ch(0, 8'hD2, 1'b1, 1'b0);
    step();
    total_cnt++; if (out_data !== 8'hD2) $display("FAIL rmid_beat2 got %h exp d2", out_data); else pass_cnt++;
    set_ch(0, 8'hD3, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    total_cnt++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0)
      $display("FAIL rmid_slot got v=%b d=%h l=%b exp v=0 d=00 l=0", out_valid, out_data, out_last); else pass_cnt++;
    total_cnt++; if (dut.state !== IDLE) $display("FAIL rmid_state got %0d exp IDLE", dut.state); else pass_cnt++;
    total_cnt++; if (in_ready !== 4'b0000) $display("FAIL rmid_ready got %b exp 0000", in_ready); else pass_cnt++;
    step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rmid_no_xfer got %b exp 0", out_valid); else pass_cnt++;
    rst = 1'b0;
    set_ch(0, 8'h00, 1'b0, 1'b0);
    sel = 2'd1;
    set_ch(1, 8'hE1, 1'b1, 1'b1);
    #1;
    total_cnt++; if (in_ready !== 4'b0010) $display("FAIL rmid_new_ready got %b exp 0010", in_ready); else pass_cnt++;
    step();
    total_cnt++; if (out_valid !== 1'b1 || out_data !== 8'hE1 || out_last !== 1'b1)
      $display("FAIL rmid_new_beat got v=%b d=%h l=%b exp v=1 d=e1 l=1", out_valid, out_data, out_last); else pass_cnt++;
    set_ch(1, 8'h00, 1'b0, 1'b0);
    step();
  endtask

`ifdef STREAM_MUX_RR_EN
  task automatic test_round_robin();
    logic [7:0] exp_d;
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    in_data = 32'hA3A2A1A0; in_last = 4'hF; in_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin
      exp_d = 8'hA0 + 8'(i % 4);
      step();
      total_cnt++; if (out_valid !== 1'b1 || out_data !== exp_d)
        $display("FAIL rr_grant%0d got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, exp_d); else pass_cnt++;
    end
    in_valid = '0;
    step();
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "watchdog");
  end

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    test_reset();
    test_basic();
    test_lock();
    test_backpressure();
    test_back_to_back();
`ifndef STREAM_MUX_RR_EN
    test_sel_range();
`endif
    test_reset_mid();
`ifdef STREAM_MUX_RR_EN
    test_round_robin();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
